// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF on-the-fly converter: digit codes, FSM states
// and the signed-digit decoder.
package msdf_pkg;

  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_NEG  = 2'b11;
  localparam logic [1:0] DIG_BAD  = 2'b10;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } otfState_t;

  typedef struct packed {
    logic sign;
    logic nonzero;
    logic bad;
  } digitInfo_t;

  // The reserved bit never affects the value; a bad code converts as zero.
  function automatic digitInfo_t decodeDigit(input logic [2:0] raw);
    digitInfo_t info;
    info.sign    = (raw[1:0] == DIG_NEG);
    info.nonzero = !((raw[1:0] == DIG_ZERO) || (raw[1:0] == DIG_BAD));
    info.bad     = raw[2] || (raw[1:0] == DIG_BAD);
    return info;
  endfunction

endpackage

// File: rtl/msdf_otf_qreg.sv
// On-the-fly conversion register pair: Q holds the converted prefix, QM holds Q minus
// one ulp, so a negative digit never needs a carry-propagating subtraction.
module msdf_otf_qreg
  import msdf_pkg::*;
#(
  parameter int OUT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [1:0]       digit,
  output logic [OUT_W-1:0] q,
  output logic [OUT_W-1:0] qNext
);

  logic [OUT_W-1:0] qm;
  logic [OUT_W-1:0] qmNext;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    qNext  = {q[OUT_W-2:0], 1'b0};
    qmNext = {qm[OUT_W-2:0], 1'b1};
    case (digit)
      DIG_POS: begin
        qNext  = {q[OUT_W-2:0], 1'b1};
        qmNext = {q[OUT_W-2:0], 1'b0};
      end
      DIG_NEG: begin
        qNext  = {qm[OUT_W-2:0], 1'b1};
        qmNext = {qm[OUT_W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q  <= '0;
      qm <= '1;
    end else if (clear) begin
      q  <= '0;
      qm <= '1;
    end else if (enable) begin
      q  <= qNext;
      qm <= qmNext;
    end
  end

endmodule

// File: rtl/msdf_otf_converter.sv
// Converts MSB-first signed radix-2 digit words to two's-complement on an elastic output.
// Define MSDF_OTF_OVERLAP_EN to accept the next word's first digit while the result drains.
module msdf_otf_converter
  import msdf_pkg::*;
#(
  parameter  int TARGET_PRECISION = 25,
  localparam int OUT_W            = TARGET_PRECISION + 1,
  localparam int CNT_W            = $clog2(TARGET_PRECISION)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       dataInArray_0,
  input  logic             pValidArray_0,
  output logic             readyArray_0,
  output logic [OUT_W-1:0] dataOutArray_0,
  output logic             validArray_0,
  input  logic             nReadyArray_0,
  output logic             err_flag
);

  otfState_t        state;
  otfState_t        stateNext;
  logic [CNT_W-1:0] cnt;
  digitInfo_t       digitInfo;
  logic [1:0]       digitCode;
  logic             digitXfer;
  logic             outXfer;
  logic             lastDigit;
  logic [OUT_W-1:0] q;
  logic [OUT_W-1:0] qNext;

  assign digitInfo = decodeDigit(dataInArray_0);
  assign digitCode = digitInfo.nonzero ? (digitInfo.sign ? DIG_NEG : DIG_POS) : DIG_ZERO;
  assign digitXfer = pValidArray_0 && readyArray_0;
  assign outXfer   = validArray_0 && nReadyArray_0;
  assign lastDigit = (cnt == CNT_W'(TARGET_PRECISION - 1));

  always_comb begin
    readyArray_0 = 1'b0;
    case (state)
      ACCUM:  readyArray_0 = 1'b1;
`ifdef MSDF_OTF_OVERLAP_EN
      OUTPUT: readyArray_0 = nReadyArray_0;
`else
      OUTPUT: readyArray_0 = 1'b0;
`endif
      default: readyArray_0 = 1'b0;
    endcase
  end

  // In OUTPUT a digit can only transfer alongside consumption, and cnt is 0 there.
  always_comb begin
    stateNext = state;
    case (state)
      ACCUM:   if (digitXfer && lastDigit) stateNext = OUTPUT;
      OUTPUT:  if (outXfer) stateNext = ACCUM;
      default: stateNext = ACCUM;
    endcase
  end

  msdf_otf_qreg #(.OUT_W(OUT_W)) u_qreg (
    .clk   (clk),
    .rst   (rst),
    .enable(digitXfer),
    .clear (digitXfer && lastDigit),
    .digit (digitCode),
    .q     (q),
    .qNext (qNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ACCUM;
      cnt            <= '0;
      dataOutArray_0 <= '0;
      validArray_0   <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      state <= stateNext;
      if (digitXfer) begin
        cnt <= lastDigit ? '0 : cnt + CNT_W'(1);
        if (digitInfo.bad) err_flag <= 1'b1;
      end
      if (digitXfer && lastDigit) begin
        dataOutArray_0 <= qNext;
        validArray_0   <= 1'b1;
      end else if (outXfer) begin
        validArray_0 <= 1'b0;
      end
    end
  end

  // Only the last-digit update is ever presented; the live prefix is internal.
  logic unusedQ;
  assign unusedQ = ^q;

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Scoreboard bench for msdf_otf_converter with 4-digit words; expected period follows
// whether MSDF_OTF_OVERLAP_EN is defined.
module tb_msdf_otf_converter;

  localparam int N     = 4;
  localparam int OUT_W = N + 1;
`ifdef MSDF_OTF_OVERLAP_EN
  localparam int PERIOD = N;
`else
  localparam int PERIOD = N + 1;
`endif

  localparam logic [2:0] P = 3'b001;
  localparam logic [2:0] Z = 3'b000;
  localparam logic [2:0] M = 3'b011;

  logic             clk;
  logic             rst;
  logic [2:0]       dataInArray_0;
  logic             pValidArray_0;
  logic             readyArray_0;
  logic [OUT_W-1:0] dataOutArray_0;
  logic             validArray_0;
  logic             nReadyArray_0;
  logic             err_flag;

  int               checks   = 0;
  int               failures = 0;
  int               cycle    = 0;
  int               outCount = 0;
  logic [OUT_W-1:0] expQ[$];
  int               outCycles[$];

  msdf_otf_converter #(.TARGET_PRECISION(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .dataInArray_0 (dataInArray_0),
    .pValidArray_0 (pValidArray_0),
    .readyArray_0  (readyArray_0),
    .dataOutArray_0(dataOutArray_0),
    .validArray_0  (validArray_0),
    .nReadyArray_0 (nReadyArray_0),
    .err_flag      (err_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  always @(negedge clk) begin
    if (rst && validArray_0 && nReadyArray_0) begin
      outCount++;
      outCycles.push_back(cycle);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h expected none", dataOutArray_0);
      end else begin
        check("word", 32'(dataOutArray_0), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic sendDigit(input logic [2:0] d);
    int guard = 0;
    dataInArray_0 = d;
    pValidArray_0 = 1'b1;
    @(negedge clk);
    while (!readyArray_0 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!readyArray_0) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pValidArray_0 = 1'b0;
    dataInArray_0 = 3'b000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [11:0] w, input logic [OUT_W-1:0] expected);
    expQ.push_back(expected);
    for (int i = 3; i >= 0; i--) sendDigit(w[i*3 +: 3]);
    pValidArray_0 = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    pValidArray_0 = 1'b0;
    dataInArray_0 = 3'b000;
    nReadyArray_0 = 1'b1;
    #1;
    check("reset_ready", 32'(readyArray_0), 32'd1);
    check("reset_valid", 32'(validArray_0), 32'd0);
    check("reset_data", 32'(dataOutArray_0), 32'd0);
    check("reset_err", 32'(err_flag), 32'd0);
    #11 rst = 1'b1;
    @(posedge clk);
    #1;

    // +1,0,-1,+1 = +7, valid the cycle after the 4th digit, one pulse only
    expQ.push_back(5'b00111);
    sendDigit(P);
    sendDigit(Z);
    sendDigit(M);
    check("latency_early", 32'(validArray_0), 32'd0);
    sendDigit(P);
    pValidArray_0 = 1'b0;
    check("latency_valid", 32'(validArray_0), 32'd1);
    idle(1);
    check("single_pulse", 32'(validArray_0), 32'd0);
    check("err_clean", 32'(err_flag), 32'd0);

    sendWord({M, M, M, M}, 5'b10001);
    idle(1);
    sendWord({P, P, P, P}, 5'b01111);
    idle(1);
    sendWord({Z, Z, Z, Z}, 5'b00000);
    idle(1);

    // Downstream stall for 6 cycles
    nReadyArray_0 = 1'b0;
    sendWord({P, Z, M, P}, 5'b00111);
    for (int i = 0; i < 6; i++) begin
      check("stall_ready", 32'(readyArray_0), 32'd0);
      check("stall_valid", 32'(validArray_0), 32'd1);
      check("stall_data", 32'(dataOutArray_0), 32'h07);
      @(posedge clk);
      #1;
    end
    nReadyArray_0 = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_consume", 32'(readyArray_0), 32'd1);
    check("valid_after_consume", 32'(validArray_0), 32'd0);

    // Bubbles mid-word
    expQ.push_back(5'b00111);
    sendDigit(P);
    idle(2);
    sendDigit(Z);
    idle(1);
    sendDigit(M);
    idle(3);
    sendDigit(P);
    idle(2);

    // Invalid codes: 3'b010 converts as 0, 3'b101 as +1 -> 8+0+2-1 = 9
    expQ.push_back(5'b01001);
    sendDigit(P);
    check("err_before", 32'(err_flag), 32'd0);
    sendDigit(3'b010);
    check("err_rise", 32'(err_flag), 32'd1);
    sendDigit(3'b101);
    sendDigit(M);
    idle(3);
    check("err_sticky", 32'(err_flag), 32'd1);

    // Reset after 2 digits: partial word discarded, outputs clear asynchronously
    sendDigit(P);
    sendDigit(P);
    pValidArray_0 = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("async_ready", 32'(readyArray_0), 32'd1);
    check("async_valid", 32'(validArray_0), 32'd0);
    check("async_data", 32'(dataOutArray_0), 32'd0);
    check("async_err", 32'(err_flag), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    sendWord({Z, P, Z, M}, 5'b00011);
    idle(2);

    // Back-to-back words at full throughput
    outCycles.delete();
    sendWord({P, Z, M, P}, 5'b00111);
    sendWord({M, Z, Z, P}, 5'b11001);
    sendWord({Z, M, P, M}, 5'b11101);
    idle(N + 4);
    check("throughput_count", 32'(outCycles.size()), 32'd3);
    if (outCycles.size() >= 3) begin
      for (int i = 1; i < 3; i++)
        check("word_period", 32'(outCycles[i] - outCycles[i-1]), 32'(PERIOD));
    end

    check("queue_drained", 32'(expQ.size()), 32'd0);
    check("output_count", 32'(outCount), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
